// File: rtl/avalon_mm_regbank_slave_if.sv
// avalon_mm_regbank_slave_if: Avalon-MM bus between a master and the register bank slave
interface avalon_mm_regbank_slave_if #(
   parameter int ADDRESS_WIDTH = 4,
   parameter int DATA_WIDTH = 32
);
   logic [ADDRESS_WIDTH-1:0] address;
   logic read;
   logic write;
   logic [DATA_WIDTH-1:0] writedata;
   logic [DATA_WIDTH/8-1:0] byteenable;
   logic [DATA_WIDTH-1:0] readdata;
   logic waitrequest;
   modport master(output address, read, write, writedata, byteenable, input readdata, waitrequest);
   modport slave(input address, read, write, writedata, byteenable, output readdata, waitrequest);
endinterface

// File: rtl/avalon_mm_regbank_slave.sv
// avalon_mm_regbank_slave: Avalon-MM slave with RW/RO register bank, wait states and error counter
module avalon_mm_regbank_slave #(
   parameter int ADDRESS_WIDTH = 4,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS = 16,
   parameter int WAIT_CYCLES = 1,
   parameter logic [NUM_REGS-1:0] RO_MASK = '0,
   parameter logic [DATA_WIDTH-1:0] REG_RESET = '0
) (
   input  logic clk,
   input  logic reset,
   avalon_mm_regbank_slave_if.slave bus,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
   output logic [NUM_REGS-1:0] reg_wr_strobe,
   output logic [7:0] err_count
);
   localparam int BE_W = DATA_WIDTH / 8;
   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
   state_t state, state_nx;
   logic [3:0] cnt;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic wr_q, both_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [BE_W-1:0] be_q;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [DATA_WIDTH-1:0] rd_val, lane_mask;
   logic [NUM_REGS-1:0] sel, commit;
   logic req, dropped, to_ack, xfer_err;
   // decode the latched transfer and compute the next FSM state
   always_comb begin
      sel = '0;
      rd_val = '0;
      lane_mask = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (addr_q == ADDRESS_WIDTH'(i)) begin
            sel[i] = 1'b1;
            rd_val = RO_MASK[i] ? hw_status[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
         end
      for (int b = 0; b < BE_W; b++) lane_mask[b*8 +: 8] = {8{be_q[b]}};
      commit = sel & ~RO_MASK;
      xfer_err = both_q | ~|sel | (wr_q & |(sel & RO_MASK));
      req = bus.read | bus.write;
      dropped = state == WAIT && !req;
      to_ack = state == WAIT && req && cnt == '0;
      state_nx = state == IDLE ? (req ? WAIT : IDLE) :
                 (state == WAIT && req && cnt != '0) ? WAIT :
                 to_ack ? ACK : IDLE;
   end
   // FSM state, transfer latch, registered bus outputs and error counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         addr_q <= '0;
         wr_q <= 1'b0;
         both_q <= 1'b0;
         wdata_q <= '0;
         be_q <= '0;
         bus.waitrequest <= 1'b1;
         bus.readdata <= '0;
         reg_wr_strobe <= '0;
         err_count <= '0;
      end else begin
         state <= state_nx;
         bus.waitrequest <= !to_ack;
         bus.readdata <= (to_ack && !wr_q) ? rd_val : '0;
         reg_wr_strobe <= (to_ack && wr_q) ? commit : '0;
         if (((to_ack && xfer_err) || dropped) && err_count != 8'hFF) err_count <= err_count + 8'd1;
         if (state == IDLE && req) begin
            addr_q <= bus.address;
            wr_q <= bus.write;
            both_q <= bus.read & bus.write;
            wdata_q <= bus.writedata;
            be_q <= bus.byteenable;
            cnt <= 4'(WAIT_CYCLES);
         end else if (state == WAIT && cnt != '0) cnt <= cnt - 4'd1;
      end
   end
   // register bank: enabled byte lanes of the target RW register update on ACK entry
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= REG_RESET;
      end else if (to_ack && wr_q) begin
         for (int i = 0; i < NUM_REGS; i++)
            if (commit[i]) regs[i] <= (regs[i] & ~lane_mask) | (wdata_q & lane_mask);
      end
   end
   // expose RW contents; read-only slots read as zero
   always_comb begin
      reg_out = '0;
      for (int i = 0; i < NUM_REGS; i++)
         reg_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs[i];
   end
endmodule
